shift_arbiter: RTL and testbench

Two-port arbiter and result stage that shares one 32-bit combinational barrel shifter between the execute-stage ALU (port 0) and the load/store alignment unit (port 1). Each port has its own valid/ready request and response handshake. The block grants at most one request per cycle by round-robin, or by fixed priority to port 0. It registers the shifted result in a single output stage tagged with the owning port, giving one-cycle latency and full throughput when responses are taken immediately.

---
 rtl/shift_arbiter.sv | 112 +++++++++++
 tb/tb_shift_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one 32-bit barrel shifter between the ALU (port 0)
// and load/store alignment (port 1), with a single owner-tagged result stage.
module shift_arbiter #(
    parameter bit PRIO_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [31:0] req_data_0,
    input  logic [4:0]  req_shamt_0,
    input  logic        req_lr_0,
    input  logic        req_al_0,
    output logic        rsp_valid_0,
    input  logic        rsp_ready_0,
    output logic [31:0] rsp_data_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [31:0] req_data_1,
    input  logic [4:0]  req_shamt_1,
    input  logic        req_lr_1,
    input  logic        req_al_1,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_data_1
);

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        lr;
        logic        al;
    } shreq_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] result_q, result_d;
    logic        rr_q, rr_d;

    shreq_t      req0, req1, sel;
    logic        drain, can_accept, gnt_port, gnt0, gnt1;
    logic [31:0] shifted;

    function automatic logic [31:0] barrel(input shreq_t r);
        logic signed [31:0] sd;
        sd = r.data;
        if (r.lr)
            return r.data << r.shamt;
        else if (r.al)
            return sd >>> r.shamt;
        else
            return r.data >> r.shamt;
    endfunction

    assign req0 = '{data: req_data_0, shamt: req_shamt_0, lr: req_lr_0, al: req_al_0};
    assign req1 = '{data: req_data_1, shamt: req_shamt_1, lr: req_lr_1, al: req_al_1};

    // Grant depends only on req_valid, rsp_ready and local state, never on rsp_valid.
    always_comb begin
        drain      = (state_q == FULL) && (owner_q ? rsp_ready_1 : rsp_ready_0);
        can_accept = (state_q == EMPTY) || drain;
        gnt_port   = 1'b0;
        if (req_valid_0 && req_valid_1)
            gnt_port = PRIO_MODE ? 1'b0 : rr_q;
        else
            gnt_port = req_valid_1;
        gnt0 = can_accept && req_valid_0 && !gnt_port;
        gnt1 = can_accept && req_valid_1 && gnt_port;
    end

    assign sel     = gnt_port ? req1 : req0;
    assign shifted = barrel(sel);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        rr_d     = rr_q;
        if (gnt0 || gnt1) begin
            state_d  = FULL;
            owner_d  = gnt_port;
            result_d = shifted;
            rr_d     = ~gnt_port;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            owner_q  <= 1'b0;
            result_q <= '0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
            rr_q     <= rr_d;
        end
    end

    assign req_ready_0 = gnt0;
    assign req_ready_1 = gnt1;
    assign rsp_valid_0 = (state_q == FULL) && !owner_q;
    assign rsp_valid_1 = (state_q == FULL) && owner_q;
    assign rsp_data_0  = rsp_valid_0 ? result_q : '0;
    assign rsp_data_1  = rsp_valid_1 ? result_q : '0;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: round-robin and fixed-priority instances driven in
// parallel, checked each cycle against an arithmetic reference model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, lr0, lr1, al0, al1, rk0, rk1;
    logic [31:0] d0, d1;
    logic [4:0]  s0, s1;
    logic [1:0]  rq0, rq1, rv0, rv1;
    logic [1:0][31:0] rd0, rd1;

    int errors = 0;
    int checks = 0;

    // Reference state per instance (index 0: round-robin, 1: fixed priority)
    bit          m_full [2];
    bit          m_own  [2];
    bit          m_rr   [2];
    logic [31:0] m_res  [2];
    bit          gseen0, gseen1;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        shift_arbiter #(.PRIO_MODE(m == 1)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid_0(v0), .req_ready_0(rq0[m]), .req_data_0(d0),
            .req_shamt_0(s0), .req_lr_0(lr0), .req_al_0(al0),
            .rsp_valid_0(rv0[m]), .rsp_ready_0(rk0), .rsp_data_0(rd0[m]),
            .req_valid_1(v1), .req_ready_1(rq1[m]), .req_data_1(d1),
            .req_shamt_1(s1), .req_lr_1(lr1), .req_al_1(al1),
            .rsp_valid_1(rv1[m]), .rsp_ready_1(rk1), .rsp_data_1(rd1[m])
        );
    end

    // Shift as multiplication / floor division by 2**s.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                              input bit lr, input bit al);
        longint p, v, r;
        p = 1;
        for (int i = 0; i < s; i++) p = p * 2;
        v = d;
        if (lr) begin
            r = v * p;
        end else if (al && d[31]) begin
            v = v - 64'sh1_0000_0000;
            r = (v - (p - 1)) / p;
        end else begin
            r = v / p;
        end
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_full[m] = 0; m_own[m] = 0; m_rr[m] = 0; m_res[m] = '0;
        end
    endtask

    // Compare both instances against the model, advance the model, cross one edge.
    task automatic step();
        bit dr, can, win, g0, g1;
        #2;
        gseen0 = rq0[0];
        gseen1 = rq1[0];
        for (int m = 0; m < 2; m++) begin
            dr  = m_full[m] && ((m_own[m] == 0) ? rk0 : rk1);
            can = !m_full[m] || dr;
            if (v0 && v1) win = (m == 1) ? 1'b0 : m_rr[m];
            else          win = v0 ? 1'b0 : 1'b1;
            g0 = can && v0 && (win == 0);
            g1 = can && v1 && (win == 1);
            chk($sformatf("m%0d req_ready_0", m), 32'(rq0[m]), 32'(g0));
            chk($sformatf("m%0d req_ready_1", m), 32'(rq1[m]), 32'(g1));
            chk($sformatf("m%0d rsp_valid_0", m), 32'(rv0[m]), 32'(m_full[m] && !m_own[m]));
            chk($sformatf("m%0d rsp_valid_1", m), 32'(rv1[m]), 32'(m_full[m] && m_own[m]));
            chk($sformatf("m%0d rsp_data_0", m), rd0[m], (m_full[m] && !m_own[m]) ? m_res[m] : 32'h0);
            chk($sformatf("m%0d rsp_data_1", m), rd1[m], (m_full[m] && m_own[m]) ? m_res[m] : 32'h0);
            if (g0 || g1) begin
                m_full[m] = 1;
                m_own[m]  = win;
                m_res[m]  = win ? ref_shift(d1, int'(s1), lr1, al1) : ref_shift(d0, int'(s0), lr0, al0);
                m_rr[m]   = !win;
            end else if (dr) begin
                m_full[m] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        v0 = 0; v1 = 0; d0 = '0; d1 = '0; s0 = '0; s1 = '0;
        lr0 = 0; lr1 = 0; al0 = 0; al1 = 0; rk0 = 1; rk1 = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom % 4)
            0:       return 32'h8000_0000 | 32'($urandom);
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom) & 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    logic [31:0] vd [4];
    logic [4:0]  vs [4];
    logic        vl [4];
    logic        va [4];
    logic [31:0] vx [4];

    initial begin
        vd = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678};
        vs = '{5'd4, 5'd31, 5'd31, 5'd0};
        vl = '{1'b0, 1'b0, 1'b1, 1'b0};
        va = '{1'b1, 1'b0, 1'b0, 1'b1};
        vx = '{32'hF800_0000, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678};

        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        chk("reset rsp_valid_0", 32'(rv0[0]), 32'h0);
        chk("reset rsp_valid_1", 32'(rv1[0]), 32'h0);
        chk("reset rsp_data_0", rd0[0], 32'h0);
        chk("reset rsp_data_1", rd1[0], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // Directed single port-0 shifts, one-cycle latency
        for (int i = 0; i < 4; i++) begin
            v0 = 1; d0 = vd[i]; s0 = vs[i]; lr0 = vl[i]; al0 = va[i];
            #1;
            chk($sformatf("vec%0d req_ready_0", i), 32'(rq0[0]), 32'h1);
            step();
            chk($sformatf("vec%0d rsp_valid_0", i), 32'(rv0[0]), 32'h1);
            chk($sformatf("vec%0d rsp_data_0", i), rd0[0], vx[i]);
            v0 = 0;
            step();
        end

        // Contention from reset: RR alternates 0,1,0,1; fixed priority always 0
        do_reset();
        v0 = 1; v1 = 1; d0 = 32'hA5A5_0F0F; d1 = 32'h0F0F_A5A5; s0 = 5'd3; s1 = 5'd7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr grant0 c%0d", i), 32'(rq0[0]), 32'((i % 2) == 0));
            chk($sformatf("prio grant0 c%0d", i), 32'(rq0[1]), 32'h1);
            step();
            chk($sformatf("rr rsp_valid_0 c%0d", i), 32'(rv0[0]), 32'((i % 2) == 0));
            chk($sformatf("rr rsp_valid_1 c%0d", i), 32'(rv1[0]), 32'((i % 2) == 1));
            chk($sformatf("prio rsp_valid_1 c%0d", i), 32'(rv1[1]), 32'h0);
        end
        v0 = 0;
        #1;
        chk("prio grant1 after drop", 32'(rq1[1]), 32'h1);
        step();
        v1 = 0;
        step();

        // Backpressure on port 1, then drain and port-0 grant in the same cycle
        do_reset();
        v1 = 1; d1 = 32'h0000_00FF; s1 = 5'd8; lr1 = 1; al1 = 0;
        step();
        v1 = 0; v0 = 1; d0 = 32'hDEAD_BEEF; s0 = 5'd1; rk1 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall rsp_data_1 c%0d", i), rd1[0], 32'h0000_FF00);
            chk($sformatf("stall req_ready_0 c%0d", i), 32'(rq0[0]), 32'h0);
            chk($sformatf("stall req_ready_1 c%0d", i), 32'(rq1[0]), 32'h0);
            step();
        end
        rk1 = 1;
        #1;
        chk("release req_ready_0", 32'(rq0[0]), 32'h1);
        step();
        chk("release rsp_valid_0", 32'(rv0[0]), 32'h1);
        v0 = 0;
        step();

        // Asynchronous reset while holding an unconsumed result
        v0 = 1; d0 = 32'h0000_1234; s0 = 5'd4; rk0 = 0;
        step();
        v0 = 0;
        chk("pre-reset rsp_valid_0", 32'(rv0[0]), 32'h1);
        rst_n = 0;
        #1;
        chk("async rsp_valid_0", 32'(rv0[0]), 32'h0);
        chk("async rsp_data_0", rd0[0], 32'h0);
        chk("async rsp_valid_0 prio", 32'(rv0[1]), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        rk0 = 1; v0 = 1; v1 = 1;
        #1;
        chk("post-reset grant0", 32'(rq0[0]), 32'h1);
        chk("post-reset grant1", 32'(rq1[0]), 32'h0);
        step();
        v0 = 0; v1 = 0;
        step();

        // Randomized traffic; requesters hold until the round-robin instance accepts
        gseen0 = 0; gseen1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!(v0 && !gseen0)) begin
                v0 = ($urandom % 3) != 0; d0 = rand_data(); s0 = 5'($urandom);
                lr0 = 1'($urandom); al0 = 1'($urandom);
            end
            if (!(v1 && !gseen1)) begin
                v1 = ($urandom % 3) != 0; d1 = rand_data(); s1 = 5'($urandom);
                lr1 = 1'($urandom); al1 = 1'($urandom);
            end
            rk0 = ($urandom % 4) != 0;
            rk1 = ($urandom % 4) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
